// File: rtl/output_display.sv
`default_nettype none
// ============================================================================
//  Module   : output_display
//  Brief    : OUT-port display. Latches a bus byte on loadDR, converts it to
//             BCD by serial double-dabble and scans it onto a 4-digit
//             common-anode 7-segment display. The sign digit and the
//             signed_mode port exist only when OUTPUT_SIGNED_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module output_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus,
    input  logic       loadDR,
`ifdef OUTPUT_SIGNED_EN
    input  logic       signed_mode,
`endif
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int                 c_REF_W     = $clog2(REFRESH_DIV);
    localparam logic [c_REF_W-1:0] c_REF_MAX   = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [6:0]         c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0]         c_SEG_MINUS = 7'b0111111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [19:0]         r_shift;
    logic [2:0]          r_cnt;
    logic                r_neg;
    logic                r_pendValid;
    logic [7:0]          r_pendMag;
    logic                r_pendNeg;
    logic [3:0]          r_dispHund;
    logic [3:0]          r_dispTens;
    logic [3:0]          r_dispOnes;
    logic                r_dispNeg;
    logic [c_REF_W-1:0]  r_refCnt;
    logic [1:0]          r_digIdx;

    logic                w_neg;
    logic [7:0]          w_mag;
    logic                w_last;
    logic [19:0]         w_adj;
    logic [19:0]         w_shifted;
    logic [1:0]          w_digSel;
    logic                w_tensBlank;
    logic [6:0]          w_segNext;
    logic [3:0]          w_anNext;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = c_SEG_BLANK;
        endcase
    endfunction

`ifdef OUTPUT_SIGNED_EN
    assign w_neg = signed_mode & bus[7];
`else
    assign w_neg = 1'b0;
`endif
    // 8-bit negation: 0x80 yields 128, which still fits the magnitude field
    assign w_mag  = w_neg ? (8'd0 - bus) : bus;
    assign w_last = (r_cnt == 3'd7);
    assign busy   = (r_state == CONV);

    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 3; i++) begin
            if (r_shift[8 + 4*i +: 4] >= 4'd5)
                w_adj[8 + 4*i +: 4] = r_shift[8 + 4*i +: 4] + 4'd3;
        end
        w_shifted = w_adj << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: if (loadDR) w_stateNext = CONV;
            CONV: if (w_last && !loadDR && !r_pendValid) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_pendValid <= 1'b0;
            r_pendMag   <= '0;
            r_pendNeg   <= 1'b0;
            r_dispHund  <= '0;
            r_dispTens  <= '0;
            r_dispOnes  <= '0;
            r_dispNeg   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (loadDR) begin
                r_shift <= {12'd0, w_mag};
                r_neg   <= w_neg;
                r_cnt   <= '0;
            end
        end else begin
            r_shift <= w_shifted;
            r_cnt   <= r_cnt + 3'd1;
            if (w_last) begin
                r_dispHund <= w_shifted[19:16];
                r_dispTens <= w_shifted[15:12];
                r_dispOnes <= w_shifted[11:8];
                r_dispNeg  <= r_neg;
                // A load on the final edge outranks anything still pending
                if (loadDR) begin
                    r_shift     <= {12'd0, w_mag};
                    r_neg       <= w_neg;
                    r_cnt       <= '0;
                    r_pendValid <= 1'b0;
                end else if (r_pendValid) begin
                    r_shift     <= {12'd0, r_pendMag};
                    r_neg       <= r_pendNeg;
                    r_cnt       <= '0;
                    r_pendValid <= 1'b0;
                end
            end else if (loadDR) begin
                r_pendValid <= 1'b1;
                r_pendMag   <= w_mag;
                r_pendNeg   <= w_neg;
            end
        end
    end

    assign w_digSel    = r_digIdx + 2'd1;
    assign w_anNext    = ~(4'b0001 << w_digSel);
    assign w_tensBlank = (r_dispHund == 4'd0) && (r_dispTens == 4'd0);

    always_comb begin
        w_segNext = c_SEG_BLANK;
        case (w_digSel)
            2'd0:    w_segNext = f_seg(r_dispOnes);
            2'd1:    w_segNext = w_tensBlank ? c_SEG_BLANK : f_seg(r_dispTens);
            2'd2:    w_segNext = (r_dispHund == 4'd0) ? c_SEG_BLANK : f_seg(r_dispHund);
            default: w_segNext = r_dispNeg ? c_SEG_MINUS : c_SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refCnt <= '0;
            r_digIdx <= '0;
            an       <= 4'b1111;
            seg      <= c_SEG_BLANK;
        end else if (r_refCnt == c_REF_MAX) begin
            r_refCnt <= '0;
            r_digIdx <= w_digSel;
            an       <= w_anNext;
            seg      <= w_segNext;
        end else begin
            r_refCnt <= r_refCnt + c_REF_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/output_display.md
# output_display

Receiving end of the CPU's OUT path: samples the data bus whenever `loadDR` is strobed and converts the byte to decimal with a sequential double-dabble (one shift per clock). It drives the result onto a 4-digit multiplexed common-anode 7-segment display. It sits beside the CPU core on the shared 8-bit bus, with `loadDR` coming from the control unit.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; minimum 2.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `bus`  in  8: CPU data bus, valid while `loadDR` is high.
- `loadDR`  in  1: load strobe; one-cycle pulse from control, sampled on the rising edge.
- `signed_mode`  in  1: interpret the byte as two's complement (only with `OUTPUT_SIGNED_EN`).
- `busy`  out  1: conversion in progress.
- `seg`  out  7: segments `gfedcba`, active-low, registered.
- `an`  out  4: digit anodes, active-low one-hot, registered; `an[0]` is ones, `an[3]` is the sign.

## Operation
- States: IDLE, CONV.
- IDLE with `loadDR`=1 at an edge:
  - Capture `bus`.
  - Magnitude = byte, or its two's-complement negation if signed and bit 7 is set. Use 8-bit unsigned negation, so 0x80 gives 128.
  - Latch the sign flag, load the 20-bit shift register (12-bit BCD, 8-bit binary), clear the 3-bit count, go to CONV.
- Each CONV edge:
  - Add 3 to any BCD nibble ≥5, shift left 1, increment the count.
  - On the 8th shift, write hundreds/tens/ones and the sign into the display registers.
- After the 8th shift:
  - Go to CONV from the pending value if one is held, otherwise go to IDLE.
  - The display registers are written on that edge in either case.
- `loadDR` during CONV (not the final edge): store the byte in a one-deep pending register; a later load overwrites it (last value wins).
- `loadDR` on the final CONV edge: the bus byte starts the next conversion directly; the pending value is discarded.
- Digit rendering:
  - Hundreds are blank if 0.
  - Tens are blank if hundreds and tens are both 0.
  - Ones are always shown.
  - `an[3]` shows minus (0111111) if the sign flag is set, otherwise blank.
- Encodings: 0=1000000, 1=1111001, 2=0100100, 5=0010010, 8=0000000, blank=1111111. The remaining digits use the standard gfedcba pattern.
- Refresh:
  - A counter runs 0..`REFRESH_DIV`-1.
  - On wrap, the digit index advances 0→1→2→3→0.
  - `an` and `seg` are reloaded for the new index on that edge.
- Reset (async, immediate):
  - State IDLE, `busy`=0, pending cleared, shift register 0.
  - Display registers hold 0, unsigned.
  - Refresh counter and digit index 0.
  - `an`=1111, `seg`=1111111.
  - Reset mid-conversion abandons the conversion; the display shows "0" once refresh resumes.

## Timing
- Load sampled at edge N; `busy` goes 1 after N and returns to 0 after edge N+8 unless a pending or simultaneous load exists.
- Display registers are updated at edge N+8, latency 8 cycles.
- Back-to-back conversions via pending run with no idle cycle.
- Segment outputs reflect new digits at the next refresh wrap after N+8.
- First digit is lit at the first refresh wrap after reset release, i.e. `REFRESH_DIV` cycles.
- Each digit is lit `REFRESH_DIV` cycles; one frame is 4×`REFRESH_DIV`.

## Configuration
- `OUTPUT_SIGNED_EN` defined: `signed_mode` port present and behaves as above.
- Not defined: port absent, every byte is unsigned, sign flag is always 0, `an[3]` is always blank.

## Test plan
- Reset then `bus`=0x00 load, `REFRESH_DIV`=4 -> `busy` high 8 cycles; frame shows an[0]=1000000, an[1..3]=blank.
- Load 0xFF unsigned -> after 8 cycles digits 2,5,5: an[2]=0100100, an[1]=0010010, an[0]=0010010, an[3] blank.
- `signed_mode`=1, load 0x80 -> minus, 1, 2, 8 (an[3]=0111111, an[0]=0000000); load 0xF6 -> minus, blank, 1, 0.
- Load 0x07, then during CONV load 0x0C and 0x2A -> 7 is displayed, then conversion continues with no gap, final display 42, 0x0C never shown.
- Load 0x05, then load 0x10 on the final CONV edge -> 5 is written, `busy` stays high, then 16 is displayed 8 cycles later.
- Assert `rst` low at CONV cycle 4 of 0x63 -> `busy`=0, `an`=1111 and `seg`=1111111 immediately; after release the display shows "0".
